multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle FSM that sequences the 16-bit CPU datapath through FETCH/DECODE/EXEC/MEM/WB.
//  Consumes the 4-bit opcode from the instruction register and drives per-stage register enables.
//  Shares one memory port between instruction fetch and lb/lw/sb/sw data access via a req/ready handshake.
//  The combinational control unit still selects muxes/ALU op; this block only decides WHEN state updates.
// PARAMETERS
//  CNT_W     16  width of retired-instruction counter instr_cnt
//  WAIT_MAX  15  max cycles mem_req may stay unanswered before ERROR (1..255)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  opcode     in   4      IR[15:12]; valid from DECODE onward
//  mem_ready  in   1      memory accepts/completes the current request this cycle
//  mem_req    out  1      memory access request (FETCH, MEM)
//  mem_wr     out  1      1 = write (MEM for sb/sw), 0 = read
//  mem_is_if  out  1      1 = address mux selects PC (FETCH), 0 = ALU result
//  ir_we      out  1      load instruction register
//  alu_we     out  1      load ALU-result register
//  mdr_we     out  1      load memory-data register (lb/lw)
//  rf_we      out  1      register-file write strobe
//  pc_we      out  1      PC update strobe (mux source from control unit pcsrc)
//  instr_done out  1      1-cycle pulse when an instruction retires
//  instr_cnt  out  CNT_W  retired-instruction count
//  state_o    out  3      current state encoding (debug)
//  err        out  1      sticky memory-timeout flag
//  step       in   1      single-step advance pulse (SINGLE_STEP_EN only)
//  halted     out  1      waiting for step (SINGLE_STEP_EN only; else tied 0)
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-low on rst_n.
//  Reset: state=FETCH, instr_cnt=0, err=0, wait_cnt=0; all strobes/mem_req 0 while rst_n=0.
//  Strobes are Moore decodes of state, except ir_we/mdr_we/sb-sw pc_we, gated by mem_ready.
//  FETCH: mem_req=1, mem_is_if=1; on mem_ready: ir_we=1 -> DECODE; else stay.
//  DECODE: no strobes, 1 cycle -> EXEC.
//  EXEC: alu_we=1.
//    op 0010/0011 (beq/ble): pc_we=1, instr_done=1 -> FETCH; taken/not-taken resolved by pcsrc.
//    op 0100-0111 -> MEM; all others -> WB.
//  MEM: mem_req=1, mem_wr = (op==0110||op==0111).
//    On mem_ready: loads set mdr_we=1 -> WB.
//    Stores set pc_we=1, instr_done=1 -> FETCH.
//  WB: rf_we=1, pc_we=1, instr_done=1 -> FETCH (jal/jalr/ALU/imm/loads).
//  Latency: branch 3 cycles, ALU/jump 4, store 4, load 5, each +N memory wait cycles.
//  instr_cnt increments on instr_done, wraps 2^CNT_W-1 -> 0 silently.
//  Timeout: wait_cnt counts cycles with mem_req=1 and mem_ready=0, cleared on handshake.
//    When it reaches WAIT_MAX -> ERROR: err=1, all strobes 0, held until reset.
//  mem_ready while mem_req=0 is ignored. opcode is sampled every cycle.
//    IR is only written in FETCH, so opcode is stable DECODE..WB.
//  rst_n low in any state (incl. mid-MEM or ERROR) aborts next edge -> FETCH; no partial writes.
// CONFIGURATION
//  SINGLE_STEP_EN defined: after a retiring state, go to HALT (halted=1, no strobes) instead of FETCH.
//    A step pulse in HALT -> FETCH next cycle; step outside HALT is ignored.
//    Out of reset the FSM enters HALT first.
//  Undefined: no HALT state, step ignored, halted tied 0.
// STRUCTURE
//  cpu_pkg: opcode localparams (OP_JAL=4'b0000 .. OP_ORI=4'b1111).
//    Also state encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=7, and an is_mem/is_store/is_branch helper.
//  Sub-module mem_wait_timer: wait_cnt counter + timeout compare, clear/enable inputs, expired output.
// TESTING
//  1) add (8'h81 top nibble 1000), mem_ready=1 always -> ir_we@c0, alu_we@c2, rf_we+pc_we@c3, instr_cnt=1.
//  2) lw with mem_ready delayed 3 cycles in MEM -> mdr_we exactly once, rf_we 1 cycle after, total 8 cycles.
//  3) sw -> mem_wr=1 in MEM, rf_we never asserted, pc_we+instr_done on ready.
//     beq -> pc_we at EXEC, no MEM/WB visit.
//  4) mem_ready held 0 in FETCH -> err=1 after 15 cycles, strobes 0 for 100 cycles.
//     rst_n=0 one cycle -> FETCH, err=0.
//  5) rst_n=0 during MEM of sb -> no mem_wr/pc_we after edge; instr_cnt=0.
//     Preload instr_cnt path to 16'hFFFF -> next retire gives 0.
//  6) SINGLE_STEP_EN: run add -> halted=1, no mem_req for 20 cycles; step pulse -> FETCH next cycle.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - opcodes, state encodings, strobe bundle and opcode class helpers
package multicycle_sequencer_pkg;

    localparam logic [3:0] OP_JAL  = 4'b0000;
    localparam logic [3:0] OP_JALR = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_BLE  = 4'b0011;
    localparam logic [3:0] OP_LB   = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SB   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_ADDI = 4'b1101;
    localparam logic [3:0] OP_ANDI = 4'b1110;
    localparam logic [3:0] OP_ORI  = 4'b1111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    typedef struct packed {
        logic mem_req;
        logic mem_wr;
        logic mem_is_if;
        logic ir_we;
        logic alu_we;
        logic mdr_we;
        logic rf_we;
        logic pc_we;
        logic instr_done;
        logic halted;
    } strobe_t;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BLE);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - shared memory port handshake between sequencer and memory
interface multicycle_sequencer_if;

    logic mem_req;
    logic mem_wr;
    logic mem_is_if;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_is_if,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_is_if,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// rtl/multicycle_sequencer_mem_wait_timer.sv - counts unanswered memory request cycles, flags timeout
module multicycle_sequencer_mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Fires during the WAIT_MAX-th unanswered cycle so ERROR is entered on that edge.
    assign expired = enable && (wait_cnt == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer; SINGLE_STEP_EN adds HALT
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             opcode,
    multicycle_sequencer_if.master mem,
    output logic                   ir_we,
    output logic                   alu_we,
    output logic                   mdr_we,
    output logic                   rf_we,
    output logic                   pc_we,
    output logic                   instr_done,
    output logic [CNT_W-1:0]       instr_cnt,
    output logic [2:0]             state_o,
    output logic                   err,
    input  logic                   step,
    output logic                   halted
);

`ifdef SINGLE_STEP_EN
    localparam logic [2:0] ST_RETIRE = ST_HALT;
`else
    localparam logic [2:0] ST_RETIRE = ST_FETCH;
    logic unused_step;
    assign unused_step = step;
`endif

    logic [2:0] state;
    logic [2:0] state_nx;
    strobe_t    s;
    strobe_t    g;
    logic       expired;

    multicycle_sequencer_mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (s.mem_req & mem.mem_ready),
        .enable  (s.mem_req & ~mem.mem_ready),
        .expired (expired)
    );

    always_comb begin
        s        = '0;
        state_nx = state;
        case (state)
            ST_FETCH: begin
                s.mem_req   = 1'b1;
                s.mem_is_if = 1'b1;
                if (mem.mem_ready) begin
                    s.ir_we  = 1'b1;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC: begin
                s.alu_we = 1'b1;
                if (is_branch(opcode)) begin
                    s.pc_we      = 1'b1;
                    s.instr_done = 1'b1;
                    state_nx     = ST_RETIRE;
                end else if (is_mem(opcode)) begin
                    state_nx = ST_MEM;
                end else begin
                    state_nx = ST_WB;
                end
            end
            ST_MEM: begin
                s.mem_req = 1'b1;
                s.mem_wr  = is_store(opcode);
                if (mem.mem_ready) begin
                    if (is_store(opcode)) begin
                        s.pc_we      = 1'b1;
                        s.instr_done = 1'b1;
                        state_nx     = ST_RETIRE;
                    end else begin
                        s.mdr_we = 1'b1;
                        state_nx = ST_WB;
                    end
                end
            end
            ST_WB: begin
                s.rf_we      = 1'b1;
                s.pc_we      = 1'b1;
                s.instr_done = 1'b1;
                state_nx     = ST_RETIRE;
            end
`ifdef SINGLE_STEP_EN
            ST_HALT: begin
                s.halted = 1'b1;
                if (step) begin
                    state_nx = ST_FETCH;
                end
            end
`endif
            ST_ERROR: state_nx = ST_ERROR;
            default:  state_nx = ST_ERROR;
        endcase
        if (expired) begin
            state_nx = ST_ERROR;
        end
    end

    // Reset is synchronous, so the outputs are masked directly while rst_n is low.
    assign g = rst_n ? s : '0;

    assign mem.mem_req   = g.mem_req;
    assign mem.mem_wr    = g.mem_wr;
    assign mem.mem_is_if = g.mem_is_if;
    assign ir_we         = g.ir_we;
    assign alu_we        = g.alu_we;
    assign mdr_we        = g.mdr_we;
    assign rf_we         = g.rf_we;
    assign pc_we         = g.pc_we;
    assign instr_done    = g.instr_done;
    assign halted        = g.halted;
    assign state_o       = state;
    assign err           = (state == ST_ERROR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RETIRE;
            instr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (s.instr_done) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer, honours SINGLE_STEP_EN
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

`ifdef SINGLE_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    typedef struct packed {
        logic mem_req, mem_wr, mem_is_if, ir_we, alu_we, mdr_we, rf_we, pc_we, instr_done, halted, err;
        logic [2:0] state;
    } outv_t;

    typedef struct {
        logic       rdy;
        logic [3:0] op;
        logic       stp;
        logic       hlt;
        outv_t      e;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        int wf, wm, lat, n_rf, n_mdr, n_wr;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        step   = 1'b0;
    logic [3:0]  opcode = 4'd0;

    logic        ir_we1, alu_we1, mdr_we1, rf_we1, pc_we1, done1, err1, halted1;
    logic [15:0] cnt1;
    logic [2:0]  st1;
    logic        ir_we2, alu_we2, mdr_we2, rf_we2, pc_we2, done2, err2, halted2;
    logic [3:0]  cnt2;
    logic [2:0]  st2;

    multicycle_sequencer_if bus();
    multicycle_sequencer_if bus2();
    assign bus2.mem_ready = bus.mem_ready;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(16), .WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem(bus),
        .ir_we(ir_we1), .alu_we(alu_we1), .mdr_we(mdr_we1), .rf_we(rf_we1), .pc_we(pc_we1),
        .instr_done(done1), .instr_cnt(cnt1), .state_o(st1), .err(err1), .step(step), .halted(halted1)
    );

    multicycle_sequencer #(.CNT_W(4), .WAIT_MAX(15)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem(bus2),
        .ir_we(ir_we2), .alu_we(alu_we2), .mdr_we(mdr_we2), .rf_we(rf_we2), .pc_we(pc_we2),
        .instr_done(done2), .instr_cnt(cnt2), .state_o(st2), .err(err2), .step(step), .halted(halted2)
    );

    outv_t act, act2;
    assign act  = {bus.mem_req, bus.mem_wr, bus.mem_is_if, ir_we1, alu_we1, mdr_we1, rf_we1, pc_we1,
                   done1, halted1, err1, st1};
    assign act2 = {bus2.mem_req, bus2.mem_wr, bus2.mem_is_if, ir_we2, alu_we2, mdr_we2, rf_we2, pc_we2,
                   done2, halted2, err2, st2};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    cyc_t        plan[$];
    int          halt_n;
    int          idx, lat, n_rf, n_mdr, n_wr;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic outv_t ov(input logic [2:0] st);
        outv_t o;
        o       = '0;
        o.state = st;
        return o;
    endfunction

    function automatic void push(input logic rdy, input logic [3:0] op, input logic stp,
                                 input logic hlt, input outv_t e);
        cyc_t c;
        c.rdy = rdy; c.op = op; c.stp = stp; c.hlt = hlt; c.e = e;
        plan.push_back(c);
    endfunction

    function automatic void plan_halt(input int hl);
        outv_t e;
        int    k;
        halt_n = 0;
        if (STEP_MODE) begin
            k = (hl < 0) ? $urandom_range(0, 3) : hl;
            e = ov(ST_HALT);
            e.halted = 1'b1;
            for (int i = 0; i < k; i++) push(rb(), rop(), 1'b0, 1'b1, e);
            push(rb(), rop(), 1'b1, 1'b1, e);
            halt_n = k + 1;
        end
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction from its class and memory wait counts.
    function automatic void plan_instr(input logic [3:0] op, input int wf, input int wm, input int hl);
        outv_t e;
        bit br = (op == 4'd2) || (op == 4'd3);
        bit mm = (op >= 4'd4) && (op <= 4'd7);
        bit st = (op == 4'd6) || (op == 4'd7);
        plan_halt(hl);
        e = ov(ST_FETCH);
        e.mem_req = 1'b1; e.mem_is_if = 1'b1;
        for (int i = 0; i < wf; i++) push(1'b0, rop(), rb(), 1'b0, e);
        e.ir_we = 1'b1;
        push(1'b1, rop(), rb(), 1'b0, e);
        push(rb(), op, rb(), 1'b0, ov(ST_DECODE));
        e = ov(ST_EXEC);
        e.alu_we = 1'b1;
        if (br) begin e.pc_we = 1'b1; e.instr_done = 1'b1; end
        push(rb(), op, rb(), 1'b0, e);
        if (mm) begin
            e = ov(ST_MEM);
            e.mem_req = 1'b1; e.mem_wr = st;
            for (int i = 0; i < wm; i++) push(1'b0, op, rb(), 1'b0, e);
            if (st) begin e.pc_we = 1'b1; e.instr_done = 1'b1; end
            else e.mdr_we = 1'b1;
            push(1'b1, op, rb(), 1'b0, e);
        end
        if (!br && !st) begin
            e = ov(ST_WB);
            e.rf_we = 1'b1; e.pc_we = 1'b1; e.instr_done = 1'b1;
            push(rb(), op, rb(), 1'b0, e);
        end
    endfunction

    task automatic cyc(input cyc_t c);
        bus.mem_ready = c.rdy;
        opcode        = c.op;
        step          = c.stp;
        @(negedge clk);
        checks++;
        if (act !== c.e || cnt1 !== exp_cnt || act2 !== c.e || cnt2 !== exp_cnt[3:0]) begin
            errors++;
            $display("FAIL cycle t=%0t: out=%h cnt=%h out_narrow=%h cnt_narrow=%h, required out=%h cnt=%h",
                     $time, act, cnt1, act2, cnt2, c.e, exp_cnt);
        end
        if (!c.hlt) begin
            idx++;
            if (act.instr_done && lat < 0) lat = idx;
            n_rf  += int'(act.rf_we);
            n_mdr += int'(act.mdr_we);
            n_wr  += int'(act.mem_wr);
        end
        if (c.e.instr_done) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int n);
        int done_n = 0;
        while (plan.size() > 0 && (n < 0 || done_n < n)) begin
            cyc(plan.pop_front());
            done_n++;
        end
        plan.delete();
    endtask

    task automatic clear_stats();
        idx = 0; lat = -1; n_rf = 0; n_mdr = 0; n_wr = 0;
    endtask

    task automatic do_reset(input int n, input logic rdy, input logic [3:0] op);
        outv_t m, m2;
        for (int i = 0; i < n; i++) begin
            rst_n = 1'b0; bus.mem_ready = rdy; opcode = op; step = rb();
            @(negedge clk);
            m = act;   m.err = 1'b0;  m.state = '0;
            m2 = act2; m2.err = 1'b0; m2.state = '0;
            checks++;
            if (m !== '0 || m2 !== '0) begin
                errors++;
                $display("FAIL reset_strobes: got %h / %h, required 0", m, m2);
            end
            @(posedge clk);
            #1;
        end
        rst_n   = 1'b1;
        exp_cnt = '0;
    endtask

    vec_t tbl[12];

    initial begin
        outv_t e;
        logic [3:0] rop_v;
        tbl[0]  = '{OP_ADD,  0,  0,  4, 1, 0, 0};
        tbl[1]  = '{OP_LW,   0,  3,  8, 1, 1, 0};
        tbl[2]  = '{OP_SW,   0,  0,  4, 0, 0, 1};
        tbl[3]  = '{OP_BEQ,  0,  0,  3, 0, 0, 0};
        tbl[4]  = '{OP_BLE,  2,  0,  5, 0, 0, 0};
        tbl[5]  = '{OP_LB,   1,  0,  6, 1, 1, 0};
        tbl[6]  = '{OP_SB,   0,  2,  6, 0, 0, 3};
        tbl[7]  = '{OP_JAL,  0,  0,  4, 1, 0, 0};
        tbl[8]  = '{OP_JALR, 14, 0, 18, 1, 0, 0};
        tbl[9]  = '{OP_LW,   0, 14, 19, 1, 1, 0};
        tbl[10] = '{OP_ORI,  3,  0,  7, 1, 0, 0};
        tbl[11] = '{OP_ADDI, 0,  5,  4, 1, 0, 0};

        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2, 1'b1, OP_ADD);

        for (int i = 0; i < 12; i++) begin
            clear_stats();
            plan_instr(tbl[i].op, tbl[i].wf, tbl[i].wm, -1);
            play(-1);
            checks++;
            if (lat != tbl[i].lat || n_rf != tbl[i].n_rf || n_mdr != tbl[i].n_mdr || n_wr != tbl[i].n_wr) begin
                errors++;
                $display("FAIL vec%0d op=%h: lat=%0d rf=%0d mdr=%0d wr=%0d, required lat=%0d rf=%0d mdr=%0d wr=%0d",
                         i, tbl[i].op, lat, n_rf, n_mdr, n_wr,
                         tbl[i].lat, tbl[i].n_rf, tbl[i].n_mdr, tbl[i].n_wr);
            end
        end

        for (int i = 0; i < 40; i++) begin
            rop_v = rop();
            clear_stats();
            plan_instr(rop_v,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2), -1);
            play(-1);
        end

        // Long halt: no memory traffic until the step pulse.
        plan_instr(OP_ADD, 0, 0, 20);
        play(-1);

        // Fetch never answered: ERROR after 15 waiting cycles, then quiet for 100 cycles.
        plan_halt(-1);
        e = ov(ST_FETCH);
        e.mem_req = 1'b1; e.mem_is_if = 1'b1;
        for (int i = 0; i < 15; i++) push(1'b0, rop(), rb(), 1'b0, e);
        e = ov(ST_ERROR);
        e.err = 1'b1;
        for (int i = 0; i < 100; i++) push(rb(), rop(), rb(), 1'b0, e);
        play(-1);
        do_reset(1, 1'b0, OP_ADD);
        plan_instr(OP_ADD, 0, 0, -1);
        play(-1);

        // Reset lands in the middle of a store's memory wait.
        plan_instr(OP_SB, 0, 5, -1);
        play(halt_n + 5);
        do_reset(1, 1'b1, OP_SB);
        plan_instr(OP_LW, 1, 1, -1);
        play(-1);
        plan_instr(OP_SW, 0, 0, -1);
        play(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
